i2c_deserializer: RTL

Receive-side front end of the I2C slave, directly upstream of the read-data serializer. Synchronizes SCL/SDA into the system clock domain and detects START, repeated START and STOP. Shifts in the address byte and compares it with the slave address; on a match it drives the ACK. For writes it assembles data bytes and hands them to the register file; for reads it issues byte-fetch strobes and per-byte phase flags to the serializer.

---
 rtl/i2c_deserializer.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_deserializer.sv
`timescale 1ns/1ps
// i2c_deserializer
// Receive-side front end of the I2C slave. Synchronizes SCL/SDA, detects
// START / repeated START / STOP, matches the address byte, drives the ACK
// for the address and write bytes, and produces byte strobes and ACK-phase
// flags for the register file (writes) and the read-data serializer (reads).
//
// Ports:
//   i_clk            system clock, >= 16x SCL
//   i_reset          synchronous, active-high reset
//   i_i2c_scl        raw SCL pin
//   i_i2c_sda        raw SDA pin
//   o_i2c_sda_oe     1 = pull SDA low (ACK), open-drain pad
//   o_i2c_wdata      last received write byte, valid with o_i2c_xfc_write
//   o_i2c_xfc_write  1-cycle strobe, write byte complete
//   o_i2c_xfc_read   1-cycle strobe, serializer loads next read byte
//   o_addr_ack       high during the address ACK slot
//   o_data_ack       high during a write-data ACK slot
//   o_slave_ack      high during the master ACK/NACK slot of a read
//   o_stop_out       1-cycle strobe on STOP or on a read-ending NACK
//
// state      | meaning
// S_IDLE     | bus free, waiting for START
// S_ADDR     | shifting in address + R/W
// S_ADDR_ACK | driving ACK for a matched address
// S_WRITE    | shifting in a write data byte
// S_WRITE_ACK| driving ACK for a write data byte
// S_READ     | serializer drives 8 data bits, we count them
// S_READ_ACK | master ACK/NACK slot of a read byte
// S_WAIT_STOP| not addressed / read ended, waiting for START or STOP
module i2c_deserializer #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_i2c_scl,
  input  logic       i_i2c_sda,
  output logic       o_i2c_sda_oe,
  output logic [7:0] o_i2c_wdata,
  output logic       o_i2c_xfc_write,
  output logic       o_i2c_xfc_read,
  output logic       o_addr_ack,
  output logic       o_data_ack,
  output logic       o_slave_ack,
  output logic       o_stop_out
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_WRITE, S_WRITE_ACK, S_READ, S_READ_ACK, S_WAIT_STOP
  } state_t;

  logic r_scl_s1, r_scl_s2, r_scl_d;
  logic r_sda_s1, r_sda_s2, r_sda_d;

  state_t     r_state, w_state_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;
  // Holds the first seven bits of a byte; the eighth is the live synced SDA.
  logic [6:0] r_shift, w_shift_nxt;
  logic       r_rw, w_rw_nxt;
  logic       r_ack_on, w_ack_on_nxt;
  logic       r_sda_oe, w_sda_oe_nxt;
  logic [7:0] r_wdata, w_wdata_nxt;
  logic       r_xfc_write, w_xfc_write_nxt;
  logic       r_xfc_read, w_xfc_read_nxt;
  logic       r_addr_ack, w_addr_ack_nxt;
  logic       r_data_ack, w_data_ack_nxt;
  logic       r_slave_ack, w_slave_ack_nxt;
  logic       r_stop_out, w_stop_out_nxt;

  logic       w_scl_rise, w_scl_fall, w_sda_rise, w_sda_fall;
  logic       w_start, w_stop;
  logic [7:0] w_byte;

  assign w_scl_rise = r_scl_s2 & ~r_scl_d;
  assign w_scl_fall = ~r_scl_s2 & r_scl_d;
  assign w_sda_rise = r_sda_s2 & ~r_sda_d;
  assign w_sda_fall = ~r_sda_s2 & r_sda_d;
  assign w_start    = w_sda_fall & r_scl_s2;
  assign w_stop     = w_sda_rise & r_scl_s2;
  assign w_byte     = {r_shift, r_sda_s2};

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_shift_nxt     = r_shift;
    w_rw_nxt        = r_rw;
    w_ack_on_nxt    = r_ack_on;
    w_sda_oe_nxt    = r_sda_oe;
    w_wdata_nxt     = r_wdata;
    w_addr_ack_nxt  = r_addr_ack;
    w_data_ack_nxt  = r_data_ack;
    w_slave_ack_nxt = r_slave_ack;
    w_xfc_write_nxt = 1'b0;
    w_xfc_read_nxt  = 1'b0;
    w_stop_out_nxt  = 1'b0;

    if (w_start || w_stop) begin
      // Bus conditions override any bit activity in the same cycle.
      w_state_nxt     = w_start ? S_ADDR : S_IDLE;
      w_stop_out_nxt  = w_stop && (r_state != S_IDLE);
      w_cnt_nxt       = 4'd0;
      w_shift_nxt     = 7'd0;
      w_ack_on_nxt    = 1'b0;
      w_sda_oe_nxt    = 1'b0;
      w_addr_ack_nxt  = 1'b0;
      w_data_ack_nxt  = 1'b0;
      w_slave_ack_nxt = 1'b0;
    end else begin
      case (r_state)
        S_ADDR, S_WRITE: begin
          if (w_scl_rise) begin
            w_shift_nxt = w_byte[6:0];
            w_cnt_nxt   = r_cnt + 4'd1;
            if (r_cnt == 4'd7) begin
              if (r_state == S_WRITE) begin
                w_wdata_nxt     = w_byte;
                w_xfc_write_nxt = 1'b1;
                w_state_nxt     = S_WRITE_ACK;
              end else if (w_byte[7:1] == SLAVE_ADDR) begin
                w_rw_nxt       = w_byte[0];
                w_xfc_read_nxt = w_byte[0];
                w_state_nxt    = S_ADDR_ACK;
              end else begin
                w_state_nxt = S_WAIT_STOP;
              end
            end
          end
        end
        S_ADDR_ACK, S_WRITE_ACK: begin
          // First fall opens the 9th-bit ACK window, second fall closes it.
          if (w_scl_fall) begin
            if (!r_ack_on) begin
              w_ack_on_nxt   = 1'b1;
              w_sda_oe_nxt   = 1'b1;
              w_addr_ack_nxt = (r_state == S_ADDR_ACK);
              w_data_ack_nxt = (r_state == S_WRITE_ACK);
            end else begin
              w_ack_on_nxt   = 1'b0;
              w_sda_oe_nxt   = 1'b0;
              w_addr_ack_nxt = 1'b0;
              w_data_ack_nxt = 1'b0;
              w_cnt_nxt      = 4'd0;
              w_state_nxt    = (r_state == S_ADDR_ACK && r_rw) ? S_READ : S_WRITE;
            end
          end
        end
        S_READ: begin
          if (w_scl_fall) begin
            w_slave_ack_nxt = 1'b0;
          end
          if (w_scl_rise) begin
            w_cnt_nxt = r_cnt + 4'd1;
            if (r_cnt == 4'd7) begin
              w_state_nxt = S_READ_ACK;
            end
          end
        end
        S_READ_ACK: begin
          if (w_scl_fall) begin
            w_slave_ack_nxt = 1'b1;
          end
          if (w_scl_rise) begin
            w_cnt_nxt = 4'd0;
            if (r_sda_s2) begin
              w_stop_out_nxt  = 1'b1;
              w_slave_ack_nxt = 1'b0;
              w_state_nxt     = S_WAIT_STOP;
            end else begin
              // slave_ack stays up until the 9th fall, cleared in S_READ.
              w_xfc_read_nxt = 1'b1;
              w_state_nxt    = S_READ;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_scl_s1    <= 1'b1;
      r_scl_s2    <= 1'b1;
      r_scl_d     <= 1'b1;
      r_sda_s1    <= 1'b1;
      r_sda_s2    <= 1'b1;
      r_sda_d     <= 1'b1;
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_shift     <= 7'd0;
      r_rw        <= 1'b0;
      r_ack_on    <= 1'b0;
      r_sda_oe    <= 1'b0;
      r_wdata     <= 8'h00;
      r_xfc_write <= 1'b0;
      r_xfc_read  <= 1'b0;
      r_addr_ack  <= 1'b0;
      r_data_ack  <= 1'b0;
      r_slave_ack <= 1'b0;
      r_stop_out  <= 1'b0;
    end else begin
      r_scl_s1    <= i_i2c_scl;
      r_scl_s2    <= r_scl_s1;
      r_scl_d     <= r_scl_s2;
      r_sda_s1    <= i_i2c_sda;
      r_sda_s2    <= r_sda_s1;
      r_sda_d     <= r_sda_s2;
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_shift     <= w_shift_nxt;
      r_rw        <= w_rw_nxt;
      r_ack_on    <= w_ack_on_nxt;
      r_sda_oe    <= w_sda_oe_nxt;
      r_wdata     <= w_wdata_nxt;
      r_xfc_write <= w_xfc_write_nxt;
      r_xfc_read  <= w_xfc_read_nxt;
      r_addr_ack  <= w_addr_ack_nxt;
      r_data_ack  <= w_data_ack_nxt;
      r_slave_ack <= w_slave_ack_nxt;
      r_stop_out  <= w_stop_out_nxt;
    end
  end

  assign o_i2c_sda_oe    = r_sda_oe;
  assign o_i2c_wdata     = r_wdata;
  assign o_i2c_xfc_write = r_xfc_write;
  assign o_i2c_xfc_read  = r_xfc_read;
  assign o_addr_ack      = r_addr_ack;
  assign o_data_ack      = r_data_ack;
  assign o_slave_ack     = r_slave_ack;
  assign o_stop_out      = r_stop_out;

endmodule
